// File: rtl/gray_code_counter.sv
// Registered up/down Gray-code counter with wrap or saturate behaviour at the
// ends of the range and a Gray-coded parallel load. Binary and Gray views are
// updated together on every edge so that a consumer in another clock domain
// only ever sees one Gray bit change per count step.
module gray_code_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic             Up,
    input  logic             SatEn,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    output logic [WIDTH-1:0] Binary,
    output logic [WIDTH-1:0] Graycode,
    output logic             Wrap,
    output logic             AtMax,
    output logic             AtMin
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Binary to reflected Gray code.
    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] binary_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic             at_max_r;
    logic             at_min_r;

    logic [WIDTH-1:0] next_bin_s;
    logic [WIDTH-1:0] next_gray_s;
    logic             next_wrap_s;

    // Next-state selection: load beats count, count beats hold; end-of-range wraps or saturates.
    always_comb begin
        next_bin_s  = binary_r;
        next_gray_s = gray_r;
        next_wrap_s = 1'b0;
        if (Load) begin
            next_bin_s  = g2b(LoadGray);
            next_gray_s = LoadGray;
        end else if (En) begin
            if (Up) begin
                if (binary_r == ONES) begin
                    if (SatEn) begin
                        next_bin_s = binary_r;
                    end else begin
                        next_bin_s  = ZERO;
                        next_wrap_s = 1'b1;
                    end
                end else begin
                    next_bin_s = binary_r + ONE;
                end
            end else begin
                if (binary_r == ZERO) begin
                    if (SatEn) begin
                        next_bin_s = binary_r;
                    end else begin
                        next_bin_s  = ONES;
                        next_wrap_s = 1'b1;
                    end
                end else begin
                    next_bin_s = binary_r - ONE;
                end
            end
            // Gray is always rederived from the new binary so both views move together.
            next_gray_s = b2g(next_bin_s);
        end else begin
            next_bin_s  = binary_r;
            next_gray_s = gray_r;
        end
    end

    // State register with synchronous active-low reset; flags registered with the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            binary_r <= RESET_VALUE;
            gray_r   <= b2g(RESET_VALUE);
            wrap_r   <= 1'b0;
            at_max_r <= (RESET_VALUE == ONES);
            at_min_r <= (RESET_VALUE == ZERO);
        end else begin
            binary_r <= next_bin_s;
            gray_r   <= next_gray_s;
            wrap_r   <= next_wrap_s;
            at_max_r <= (next_bin_s == ONES);
            at_min_r <= (next_bin_s == ZERO);
        end
    end

    assign Binary   = binary_r;
    assign Graycode = gray_r;
    assign Wrap     = wrap_r;
    assign AtMax    = at_max_r;
    assign AtMin    = at_min_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: a 4-bit instance driven with directed
// steps whose expectations are literal constants, and an 8-bit instance with
// RESET_VALUE=9 driven with a random mix and checked against a reference model.
module tb_gray_code_counter;

    typedef struct {
        string      tag;
        logic [7:0] bin;
        logic [7:0] gray;
        logic       wrap;
        logic       amax;
        logic       amin;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b0, sat_a = 1'b0, load_a = 1'b0;
    logic [3:0] lg_a  = 4'b0000;
    logic [3:0] bin_a, gray_a;
    logic       wrap_a, max_a, min_a;

    // 8-bit instance, RESET_VALUE = 9
    logic       rst_b = 1'b0, en_b = 1'b0, up_b = 1'b0, sat_b = 1'b0, load_b = 1'b0;
    logic [7:0] lg_b  = 8'h00;
    logic [7:0] bin_b, gray_b;
    logic       wrap_b, max_b, min_b;

    gray_code_counter #(.WIDTH(4), .RESET_VALUE(4'd0)) dut_a (
        .clk(clk), .rst_n(rst_a), .En(en_a), .Up(up_a), .SatEn(sat_a), .Load(load_a),
        .LoadGray(lg_a), .Binary(bin_a), .Graycode(gray_a), .Wrap(wrap_a),
        .AtMax(max_a), .AtMin(min_a)
    );

    gray_code_counter #(.WIDTH(8), .RESET_VALUE(8'd9)) dut_b (
        .clk(clk), .rst_n(rst_b), .En(en_b), .Up(up_b), .SatEn(sat_b), .Load(load_b),
        .LoadGray(lg_b), .Binary(bin_b), .Graycode(gray_b), .Wrap(wrap_b),
        .AtMax(max_b), .AtMin(min_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gray of an 8-bit binary value, bit by bit.
    function automatic logic [7:0] ref_gray(input logic [7:0] b);
        logic [7:0] g;
        g[7] = b[7];
        for (int i = 0; i < 7; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    // Binary of an 8-bit Gray value by prefix XOR from the top.
    function automatic logic [7:0] ref_bin(input logic [7:0] g);
        logic [7:0] b;
        logic       acc;
        acc = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    // One directed step on the 4-bit instance with literal expectations.
    task automatic step_a(input logic r, input logic l, input logic e, input logic u,
                          input logic s, input logic [3:0] lg,
                          input logic [3:0] eb, input logic [3:0] eg,
                          input logic ew, input logic emax, input logic emin,
                          input string tag);
        exp_t x;
        exp_t y;
        rst_a = r; load_a = l; en_a = e; up_a = u; sat_a = s; lg_a = lg;
        x.tag = tag; x.bin = {4'b0000, eb}; x.gray = {4'b0000, eg};
        x.wrap = ew; x.amax = emax; x.amin = emin;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        y = sb_q.pop_front();
        check({y.tag, ".bin"},  {28'd0, bin_a},  {24'd0, y.bin});
        check({y.tag, ".gray"}, {28'd0, gray_a}, {24'd0, y.gray});
        check({y.tag, ".wrap"}, {31'd0, wrap_a}, {31'd0, y.wrap});
        check({y.tag, ".max"},  {31'd0, max_a},  {31'd0, y.amax});
        check({y.tag, ".min"},  {31'd0, min_a},  {31'd0, y.amin});
    endtask

    logic [7:0] m_bin = 8'd9;
    logic       m_wrap = 1'b0;

    // One model-checked step on the 8-bit instance.
    task automatic step_b(input logic r, input logic l, input logic e, input logic u,
                          input logic s, input logic [7:0] lg, input string tag);
        exp_t       x;
        exp_t       y;
        logic [7:0] prev_gray;
        logic       moved;
        prev_gray = ref_gray(m_bin);
        rst_b = r; load_b = l; en_b = e; up_b = u; sat_b = s; lg_b = lg;
        m_wrap = 1'b0;
        moved  = 1'b0;
        if (!r) begin
            m_bin = 8'd9;
        end else if (l) begin
            m_bin = ref_bin(lg);
        end else if (e) begin
            if (u && m_bin == 8'hFF) begin
                if (!s) begin m_bin = 8'h00; m_wrap = 1'b1; moved = 1'b1; end
            end else if (!u && m_bin == 8'h00) begin
                if (!s) begin m_bin = 8'hFF; m_wrap = 1'b1; moved = 1'b1; end
            end else begin
                m_bin = u ? m_bin + 8'd1 : m_bin - 8'd1;
                moved = 1'b1;
            end
        end
        x.tag = tag; x.bin = m_bin; x.gray = ref_gray(m_bin); x.wrap = m_wrap;
        x.amax = (m_bin == 8'hFF); x.amin = (m_bin == 8'h00);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        y = sb_q.pop_front();
        check({y.tag, ".bin"},  {24'd0, bin_b},  {24'd0, y.bin});
        check({y.tag, ".gray"}, {24'd0, gray_b}, {24'd0, y.gray});
        check({y.tag, ".wrap"}, {31'd0, wrap_b}, {31'd0, y.wrap});
        check({y.tag, ".max"},  {31'd0, max_b},  {31'd0, y.amax});
        check({y.tag, ".min"},  {31'd0, min_b},  {31'd0, y.amin});
        if (moved) begin
            check({y.tag, ".onebit"}, $countones(prev_gray ^ gray_b), 32'd1);
        end
    endtask

    initial begin
        // Reset, then count up five times.
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, "reset");
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'b0001, 1'b0, 1'b0, 1'b0, "up1");
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h2, 4'b0011, 1'b0, 1'b0, 1'b0, "up2");
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 4'b0010, 1'b0, 1'b0, 1'b0, "up3");
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h4, 4'b0110, 1'b0, 1'b0, 1'b0, "up4");
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h5, 4'b0111, 1'b0, 1'b0, 1'b0, "up5");
        // Load all-ones, wrap up to zero, then Wrap must drop.
        step_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 4'hF, 4'b1000, 1'b0, 1'b1, 1'b0, "loadmax");
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, "wrapup");
        step_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, "holdafterwrap");
        // Wrap down from zero, reload zero, then saturate at zero.
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'b1000, 1'b1, 1'b1, 1'b0, "wrapdown");
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, "loadzero");
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, "satdown");
        // Saturate at all-ones for three cycles.
        step_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 4'hF, 4'b1000, 1'b0, 1'b1, 1'b0, "loadmax2");
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'hF, 4'b1000, 1'b0, 1'b1, 1'b0, "satup");
        end
        // Load wins over count; then a down step; then reset wins over load and count.
        step_a(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0111, 4'h5, 4'b0111, 1'b0, 1'b0, 1'b0, "loadwins");
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h4, 4'b0110, 1'b0, 1'b0, 1'b0, "down");
        step_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, "resetwins");

        // 8-bit instance: reset to 9, then a random mix including loads near the ends.
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "b_reset");
        check("b_reset_bin9",   {24'd0, bin_b},  32'd9);
        check("b_reset_gray13", {24'd0, gray_b}, 32'd13);
        for (int i = 0; i < 400; i++) begin
            logic [7:0] lg;
            logic       ld;
            int         pick;
            pick = $urandom_range(0, 19);
            ld   = (pick < 2);
            lg   = (pick == 0) ? 8'h80 : ((pick == 1) ? 8'h00 : 8'($urandom));
            step_b(($urandom_range(0, 99) != 0), ld, ($urandom_range(0, 3) != 0),
                   1'($urandom), ($urandom_range(0, 2) == 0), lg, "b_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
